// File: rtl/seq_div_pkg.sv
// seq_div_pkg: divider FSM state encoding and counter width helper
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: ripple subtractor a-b as a+~b+1; ports a,b in, diff and no_borrow (carry-out) out
module div_sub_stage #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);
  logic [N-1:0] nb;
  logic [N:0]   c;
  assign nb = ~b;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i] = a[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end
  assign no_borrow = c[N];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring WIDTH-bit divider, one quotient bit per clk, valid/ready request (dividend,divisor) and result (quotient,remainder,div_by_zero) ports; SEQ_DIV_SIGNED_EN selects two's-complement operands
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import seq_div_pkg::*;
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, rem, dsr, mag_dvd, mag_dsr, q_n, rem_n, q_fin, r_fin;
  logic [WIDTH:0] shifted, diff;
  logic no_borrow, qbit;
  assign shifted = {rem, dvd[WIDTH-1]};
  div_sub_stage #(.N(WIDTH + 1)) u_sub (
    .a(shifted),
    .b({1'b0, dsr}),
    .diff(diff),
    .no_borrow(no_borrow)
  );
  assign qbit = no_borrow & ~diff[WIDTH];
  assign rem_n = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_n = {dvd[WIDTH-2:0], qbit};
`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign mag_dvd = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_dsr = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = q_neg ? -q_n : q_n;
  assign r_fin = r_neg ? -rem_n : rem_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end
`else
  assign mag_dvd = dividend;
  assign mag_dsr = divisor;
  assign q_fin = q_n;
  assign r_fin = rem_n;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd         <= mag_dvd;
          dsr         <= mag_dsr;
          rem         <= '0;
          in_ready    <= 1'b0;
          div_by_zero <= divisor == '0;
          if (divisor == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
          end else begin
            state <= CALC;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          rem <= rem_n;
          dvd <= q_n;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_fin;
            remainder <= r_fin;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed check of seq_divider against an arithmetic reference model
module tb_seq_divider;
  localparam int W = 32;
  logic clk = 0;
  logic rst_n = 1;
  logic in_valid = 0, out_ready = 0;
  logic [W-1:0] dividend = 0, divisor = 0;
  logic in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int n_cmp = 0, n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Model: busy from accept to result handshake; left = edges until the result is due.
  bit busy = 0;
  int left = 0;
  logic [W-1:0] exp_q = 0, exp_r = 0, pend_q, pend_r;
  logic exp_dbz = 0, pend_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      left = 0;
      exp_q = 0;
      exp_r = 0;
      exp_dbz = 0;
    end else if (!busy) begin
      if (in_valid) begin
        ref_div(dividend, divisor, pend_q, pend_r, pend_z);
        busy = 1;
        exp_dbz = pend_z;
        left = pend_z ? 0 : W;
        if (pend_z) begin
          exp_q = pend_q;
          exp_r = pend_r;
        end
      end
    end else if (left == 0) begin
      if (out_ready) busy = 0;
    end else begin
      left--;
      if (left == 0) begin
        exp_q = pend_q;
        exp_r = pend_r;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_by_zero", div_by_zero, 0);
    end else begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, busy && left == 0);
      chk("div_by_zero", div_by_zero, exp_dbz);
      if (!busy || left == 0) begin
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit lit,
                    input logic [W-1:0] eq, input logic [W-1:0] er,
                    output logic [W-1:0] gq, output logic [W-1:0] gr);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    in_valid = 1;
    dividend = a;
    divisor = b;
    out_ready = (hold == 0);
    @(negedge clk);
    dividend = $urandom;
    divisor = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    gq = quotient;
    gr = remainder;
    if (lit) begin
      chk("lit_quotient", quotient, eq);
      chk("lit_remainder", remainder, er);
    end
    repeat (hold) @(negedge clk);
    out_ready = 1;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] gq, gr, a, b;
    logic [63:0] prod;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op(100, 7, 0, 1, 14, 2, gq, gr);
    op(32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFF, 0, gq, gr);
    op(5, 9, 0, 1, 0, 5, gq, gr);
    op(1234, 0, 0, 1, 32'hFFFF_FFFF, 1234, gq, gr);
    op(8, 2, 0, 1, 4, 0, gq, gr);
    op(1000, 3, 10, 1, 333, 1, gq, gr);
    op(0, 77, 0, 1, 0, 0, gq, gr);
    in_valid = 1;
    dividend = 50;
    divisor = 5;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    op(50, 5, 0, 1, 10, 0, gq, gr);
`ifdef SEQ_DIV_SIGNED_EN
    op(-7, 2, 0, 1, -3, -1, gq, gr);
    op(7, -2, 0, 1, -3, 1, gq, gr);
    op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 0, gq, gr);
`endif
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 1;
        2, 3: b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      op(a, b, $urandom_range(0, 3), 0, 0, 0, gq, gr);
`ifndef SEQ_DIV_SIGNED_EN
      if (b != 0) begin
        prod = 64'(gq) * 64'(b) + 64'(gr);
        chk("inv_hi", prod[63:32], 0);
        chk("inv_lo", prod[31:0], a);
        chk("inv_rem_lt", W'(gr < b), 1);
      end
`endif
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
